// File: rtl/imem_responder_pkg.sv
// Shared types for the instruction-memory responder: FSM states and the
// buffered response format.
package imem_responder_pkg;

    typedef enum logic {
        IDLE,
        WAIT
    } state_e;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } resp_t;

    localparam int unsigned CNT_W  = 4;
    localparam int unsigned RESP_W = $bits(resp_t);

    function automatic logic is_misaligned(input logic [31:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/imem_responder_resp_fifo.sv
// Synchronous response FIFO with occupancy count and single-cycle flush.
// Reads show zero while empty so the responder outputs stay quiet.
module resp_fifo
    import imem_responder_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        flush,
    input  logic                        push,
    input  logic [RESP_W-1:0]           wdata,
    input  logic                        pop,
    output logic [RESP_W-1:0]           rdata,
    output logic                        empty,
    output logic [$clog2(DEPTH):0]      count
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [RESP_W-1:0] mem [DEPTH];
    logic [PW-1:0]     wptr;
    logic [PW-1:0]     rptr;
    logic              full;
    logic              do_push;
    logic              do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop & ~empty;
    // A push into a full FIFO is only legal when the head leaves in the same cycle.
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else if (flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + PW'(1);
            if (do_pop)  rptr <= rptr + PW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push && !flush) mem[wptr] <= wdata;
    end

    assign rdata = empty ? '0 : mem[rptr];

endmodule

// File: rtl/imem_responder.sv
// Fetch-side responder: grants fetch reads against FIFO credit, drives a
// synchronous SRAM after WAIT_STATES cycles and returns words in order.
module imem_responder
    import imem_responder_pkg::*;
#(
    parameter int unsigned WAIT_STATES = 0,
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned AW          = 12
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          mem_rd_i,
    input  logic [31:0]   mem_addr_i,
    output logic          mem_gnt_o,
    input  logic          flush_i,
    output logic          rvalid_o,
    input  logic          rready_i,
    output logic [31:0]   rdata_o,
    output logic          rerr_o,
    output logic          sram_en_o,
    output logic [AW-1:0] sram_addr_o,
    input  logic [31:0]   sram_rdata_i
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0] CNT_LOAD =
        (WAIT_STATES > 0) ? CNT_W'(WAIT_STATES - 1) : '0;

    state_e            state;
    state_e            state_next;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_next;
    logic [AW-1:0]     addr_q;
    logic              err_q;
    logic [AW-1:0]     acc_addr;
    logic              acc_err;
    logic              access;
    logic              misaligned;
    logic              credit;
    logic              grant;
    logic              pend_q;
    logic              pend_err_q;
    logic              push;
    logic              pop;
    logic [CW-1:0]     inflight;
    logic [CW-1:0]     fifo_count;
    logic              fifo_empty;
    resp_t             push_resp;
    resp_t             head;
    logic [RESP_W-1:0] head_bits;
    logic              unused_addr_bits;

    assign unused_addr_bits = ^mem_addr_i[31:AW+2];

    assign misaligned = is_misaligned(mem_addr_i);
    // Credit reserves a FIFO slot for every granted request not yet pushed.
    assign credit = ({1'b0, fifo_count} + {1'b0, inflight}) < (CW + 1)'(DEPTH);
    assign grant  = rst_ni & (state == IDLE) & mem_rd_i & credit & ~flush_i;
    assign mem_gnt_o = grant;

    always_comb begin
        access   = 1'b0;
        acc_err  = 1'b0;
        acc_addr = '0;
        if (WAIT_STATES == 0) begin
            access   = grant;
            acc_err  = misaligned;
            acc_addr = mem_addr_i[AW+1:2];
        end else begin
            access   = (state == WAIT) & (cnt == '0) & ~flush_i;
            acc_err  = err_q;
            acc_addr = addr_q;
        end
    end

    assign sram_en_o   = access & ~acc_err;
    assign sram_addr_o = sram_en_o ? acc_addr : '0;

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        unique case (state)
            IDLE: begin
                if (grant && WAIT_STATES != 0) begin
                    state_next = WAIT;
                    cnt_next   = CNT_LOAD;
                end
            end
            WAIT: begin
                if (flush_i || cnt == '0) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt - CNT_W'(1);
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            addr_q <= '0;
            err_q  <= 1'b0;
        end else if (grant) begin
            addr_q <= mem_addr_i[AW+1:2];
            err_q  <= misaligned;
        end
    end

    // The data stage pushes one cycle after access unless a flush drops it.
    assign push = pend_q & ~flush_i;
    assign pop  = rvalid_o & rready_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pend_q     <= 1'b0;
            pend_err_q <= 1'b0;
            inflight   <= '0;
        end else begin
            pend_q     <= access;
            pend_err_q <= acc_err;
            if (flush_i) inflight <= '0;
            else         inflight <= inflight + CW'(grant) - CW'(push);
        end
    end

    assign push_resp.rdata = pend_err_q ? 32'h0 : sram_rdata_i;
    assign push_resp.err   = pend_err_q;

    resp_fifo #(
        .DEPTH(DEPTH)
    ) u_resp_fifo (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .flush  (flush_i),
        .push   (push),
        .wdata  (push_resp),
        .pop    (pop),
        .rdata  (head_bits),
        .empty  (fifo_empty),
        .count  (fifo_count)
    );

    assign head     = resp_t'(head_bits);
    assign rvalid_o = ~fifo_empty;
    assign rdata_o  = head.rdata;
    assign rerr_o   = head.err;

endmodule

// File: tb/tb_imem_responder.sv
// Scoreboard bench for imem_responder: three instances (W=0, W=3, W=2)
// with a behavioural synchronous SRAM each.
module tb_imem_responder;

    logic        clk;
    logic        rst_n  [3];
    logic        rd     [3];
    logic [31:0] addr   [3];
    logic        gnt    [3];
    logic        flush  [3];
    logic        rvalid [3];
    logic        rready [3];
    logic [31:0] rdata  [3];
    logic        rerr   [3];
    logic        sen    [3];
    logic [11:0] saddr  [3];
    logic [31:0] sdata  [3];

    int unsigned tests;
    int unsigned fails;
    logic [32:0] exp_q [$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] word(input logic [11:0] a);
        return 32'hC0DE_0000 ^ {a, 4'h5, a, 4'hA};
    endfunction

    function automatic logic [32:0] expect_of(input logic [31:0] a);
        if (a[1:0] != 2'b00) return {32'h0, 1'b1};
        return {word(a[13:2]), 1'b0};
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < 3; i++)
            if (sen[i]) sdata[i] <= word(saddr[i]);
    end

    imem_responder #(.WAIT_STATES(0), .DEPTH(4), .AW(12)) u_w0 (
        .clk_i(clk), .rst_ni(rst_n[0]), .mem_rd_i(rd[0]), .mem_addr_i(addr[0]),
        .mem_gnt_o(gnt[0]), .flush_i(flush[0]), .rvalid_o(rvalid[0]),
        .rready_i(rready[0]), .rdata_o(rdata[0]), .rerr_o(rerr[0]),
        .sram_en_o(sen[0]), .sram_addr_o(saddr[0]), .sram_rdata_i(sdata[0]));

    imem_responder #(.WAIT_STATES(3), .DEPTH(4), .AW(12)) u_w3 (
        .clk_i(clk), .rst_ni(rst_n[1]), .mem_rd_i(rd[1]), .mem_addr_i(addr[1]),
        .mem_gnt_o(gnt[1]), .flush_i(flush[1]), .rvalid_o(rvalid[1]),
        .rready_i(rready[1]), .rdata_o(rdata[1]), .rerr_o(rerr[1]),
        .sram_en_o(sen[1]), .sram_addr_o(saddr[1]), .sram_rdata_i(sdata[1]));

    imem_responder #(.WAIT_STATES(2), .DEPTH(4), .AW(12)) u_w2 (
        .clk_i(clk), .rst_ni(rst_n[2]), .mem_rd_i(rd[2]), .mem_addr_i(addr[2]),
        .mem_gnt_o(gnt[2]), .flush_i(flush[2]), .rvalid_o(rvalid[2]),
        .rready_i(rready[2]), .rdata_o(rdata[2]), .rerr_o(rerr[2]),
        .sram_en_o(sen[2]), .sram_addr_o(saddr[2]), .sram_rdata_i(sdata[2]));

    task automatic test_reset();
        repeat (2) @(negedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            tests++;
            if ({gnt[i], rvalid[i], rdata[i], rerr[i], sen[i], saddr[i]} !== 48'h0) begin
                fails++;
                $display("FAIL reset_outputs inst=%0d got gnt=%b rvalid=%b rdata=%h rerr=%b sen=%b saddr=%h, want all 0",
                         i, gnt[i], rvalid[i], rdata[i], rerr[i], sen[i], saddr[i]);
            end
        end
        @(negedge clk);
        rd[0]   = 1'b0;
        addr[0] = '0;
        for (int i = 0; i < 3; i++) rst_n[i] = 1'b1;
    endtask

    task automatic test_stream();
        logic [32:0] e;
        exp_q.delete();
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            rd[0] = (c < 3); addr[0] = 32'(4 * c); rready[0] = 1'b1;
            #1;
            if (c < 3) begin
                tests++;
                if (gnt[0] !== 1'b1) begin
                    fails++; $display("FAIL stream_gnt c=%0d got %b want 1", c, gnt[0]);
                end
                tests++;
                if ({sen[0], saddr[0]} !== {1'b1, 12'(c)}) begin
                    fails++; $display("FAIL stream_sram c=%0d got en=%b addr=%h want en=1 addr=%h", c, sen[0], saddr[0], 12'(c));
                end
            end
            tests++;
            if (rvalid[0] !== (c >= 2 && c <= 4)) begin
                fails++; $display("FAIL stream_rvalid c=%0d got %b want %b", c, rvalid[0], (c >= 2 && c <= 4));
            end
            if (gnt[0]) exp_q.push_back(expect_of(addr[0]));
            if (rvalid[0] && rready[0]) begin
                e = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
                tests++;
                if ({rdata[0], rerr[0]} !== e) begin
                    fails++; $display("FAIL stream_data c=%0d got %h/%b want %h/%b", c, rdata[0], rerr[0], e[32:1], e[0]);
                end
            end
        end
        tests++;
        if (exp_q.size() != 0) begin
            fails++; $display("FAIL stream_leftover got %0d pending want 0", exp_q.size());
        end
    endtask

    task automatic test_wait();
        logic [32:0] e;
        exp_q.delete();
        for (int c = 0; c < 19; c++) begin
            @(negedge clk);
            rd[1]     = (c <= 3) || (c >= 8 && c <= 12);
            addr[1]   = (c <= 3) ? 32'h10 : ((c < 12) ? 32'h30 : 32'h34);
            flush[1]  = (c == 11);
            rready[1] = 1'b1;
            #1;
            tests++;
            if (gnt[1] !== (c == 0 || c == 8 || c == 12)) begin
                fails++; $display("FAIL wait_gnt c=%0d got %b want %b", c, gnt[1], (c == 0 || c == 8 || c == 12));
            end
            tests++;
            if (sen[1] !== (c == 3 || c == 15)) begin
                fails++; $display("FAIL wait_sram_en c=%0d got %b want %b", c, sen[1], (c == 3 || c == 15));
            end
            if (c == 3 || c == 15) begin
                tests++;
                if (saddr[1] !== ((c == 3) ? 12'h004 : 12'h00D)) begin
                    fails++; $display("FAIL wait_sram_addr c=%0d got %h want %h", c, saddr[1], (c == 3) ? 12'h004 : 12'h00D);
                end
            end
            tests++;
            if (rvalid[1] !== (c == 5 || c == 17)) begin
                fails++; $display("FAIL wait_rvalid c=%0d got %b want %b", c, rvalid[1], (c == 5 || c == 17));
            end
            if (flush[1]) exp_q.delete();
            if (gnt[1]) exp_q.push_back(expect_of(addr[1]));
            if (rvalid[1] && rready[1]) begin
                e = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
                tests++;
                if ({rdata[1], rerr[1]} !== e) begin
                    fails++; $display("FAIL wait_data c=%0d got %h/%b want %h/%b", c, rdata[1], rerr[1], e[32:1], e[0]);
                end
            end
        end
        flush[1] = 1'b0; rd[1] = 1'b0;
    endtask

    task automatic test_full();
        logic [32:0] e;
        exp_q.delete();
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            rd[0]     = (c <= 10);
            addr[0]   = 32'h40 + 32'(4 * c);
            rready[0] = (c == 8) || (c >= 11);
            #1;
            if (c <= 10) begin
                tests++;
                if (gnt[0] !== (c < 4 || c == 9)) begin
                    fails++; $display("FAIL full_gnt c=%0d got %b want %b", c, gnt[0], (c < 4 || c == 9));
                end
            end
            if (gnt[0]) exp_q.push_back(expect_of(addr[0]));
            if (rvalid[0] && rready[0]) begin
                e = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
                tests++;
                if ({rdata[0], rerr[0]} !== e) begin
                    fails++; $display("FAIL full_data c=%0d got %h/%b want %h/%b", c, rdata[0], rerr[0], e[32:1], e[0]);
                end
            end
        end
        tests++;
        if (exp_q.size() != 0 || rvalid[0] !== 1'b0) begin
            fails++; $display("FAIL full_drain got %0d pending rvalid=%b want 0 pending rvalid=0", exp_q.size(), rvalid[0]);
        end
    endtask

    task automatic test_misaligned();
        logic [32:0] e;
        exp_q.delete();
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            rd[0] = (c == 0); addr[0] = 32'h6; rready[0] = 1'b1;
            #1;
            if (c == 0) begin
                tests++;
                if ({gnt[0], sen[0]} !== 2'b10) begin
                    fails++; $display("FAIL misaligned_gnt got gnt=%b sen=%b want gnt=1 sen=0", gnt[0], sen[0]);
                end
            end
            tests++;
            if (rvalid[0] !== (c == 2)) begin
                fails++; $display("FAIL misaligned_rvalid c=%0d got %b want %b", c, rvalid[0], (c == 2));
            end
            if (gnt[0]) exp_q.push_back(expect_of(addr[0]));
            if (rvalid[0] && rready[0]) begin
                e = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
                tests++;
                if ({rdata[0], rerr[0]} !== e) begin
                    fails++; $display("FAIL misaligned_data got %h/%b want %h/%b", rdata[0], rerr[0], e[32:1], e[0]);
                end
            end
        end
    endtask

    task automatic test_flush();
        logic [32:0] e;
        exp_q.delete();
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            rd[0]     = (c <= 3) || (c == 5);
            addr[0]   = (c <= 3) ? 32'h80 + 32'(4 * c) : 32'h8C;
            rready[0] = (c >= 5);
            flush[0]  = (c == 3);
            #1;
            if (c == 3) begin
                tests++;
                if ({gnt[0], rvalid[0]} !== 2'b01) begin
                    fails++; $display("FAIL flush_cycle got gnt=%b rvalid=%b want gnt=0 rvalid=1", gnt[0], rvalid[0]);
                end
            end
            if (c == 5) begin
                tests++;
                if (gnt[0] !== 1'b1) begin
                    fails++; $display("FAIL flush_regrant got %b want 1", gnt[0]);
                end
            end
            if (c >= 4) begin
                tests++;
                if (rvalid[0] !== (c == 7)) begin
                    fails++; $display("FAIL flush_rvalid c=%0d got %b want %b", c, rvalid[0], (c == 7));
                end
            end
            if (flush[0]) exp_q.delete();
            if (gnt[0]) exp_q.push_back(expect_of(addr[0]));
            if (rvalid[0] && rready[0]) begin
                e = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
                tests++;
                if ({rdata[0], rerr[0]} !== e) begin
                    fails++; $display("FAIL flush_data c=%0d got %h/%b want %h/%b", c, rdata[0], rerr[0], e[32:1], e[0]);
                end
            end
        end
        flush[0] = 1'b0; rd[0] = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [32:0] e;
        exp_q.delete();
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (c == 3) rst_n[2] = 1'b1;
            rd[2]     = (c == 0) || (c == 3);
            addr[2]   = (c == 0) ? 32'h20 : 32'h24;
            rready[2] = 1'b1;
            #1;
            if (c == 1) begin
                rst_n[2] = 1'b0;
                exp_q.delete();
                #1;
            end
            if (c == 1 || c == 2) begin
                tests++;
                if ({gnt[2], rvalid[2], rdata[2], rerr[2], sen[2], saddr[2]} !== 48'h0) begin
                    fails++;
                    $display("FAIL midreset_outputs c=%0d got gnt=%b rvalid=%b rdata=%h rerr=%b sen=%b saddr=%h, want all 0",
                             c, gnt[2], rvalid[2], rdata[2], rerr[2], sen[2], saddr[2]);
                end
            end
            if (c == 3) begin
                tests++;
                if (gnt[2] !== 1'b1) begin
                    fails++; $display("FAIL midreset_first_gnt got %b want 1", gnt[2]);
                end
            end
            if (c >= 3) begin
                tests++;
                if ({sen[2], saddr[2]} !== ((c == 5) ? {1'b1, 12'h009} : 13'h0)) begin
                    fails++; $display("FAIL midreset_sram c=%0d got en=%b addr=%h", c, sen[2], saddr[2]);
                end
                tests++;
                if (rvalid[2] !== (c == 7)) begin
                    fails++; $display("FAIL midreset_rvalid c=%0d got %b want %b", c, rvalid[2], (c == 7));
                end
            end
            if (gnt[2]) exp_q.push_back(expect_of(addr[2]));
            if (rvalid[2] && rready[2]) begin
                e = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
                tests++;
                if ({rdata[2], rerr[2]} !== e) begin
                    fails++; $display("FAIL midreset_data c=%0d got %h/%b want %h/%b", c, rdata[2], rerr[2], e[32:1], e[0]);
                end
            end
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        for (int i = 0; i < 3; i++) begin
            rst_n[i]  = 1'b0;
            rd[i]     = 1'b0;
            addr[i]   = '0;
            flush[i]  = 1'b0;
            rready[i] = 1'b1;
        end
        rd[0]   = 1'b1;
        addr[0] = 32'h4;
        test_reset();
        test_stream();
        test_wait();
        test_full();
        test_misaligned();
        test_flush();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
